// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit/receive paths.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam int CLKS_PER_BIT_DEF = 434;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Restartable modulo-CLKS_PER_BIT counter; tick marks the last cycle of each bit period.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = cnt_w(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || restart || (cnt == LAST)) cnt <= '0;
    else                                 cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: loads/shifts an external right-shift register and drives txd.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int NBIT         = 8,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tx_valid,
  output logic            tx_ready,
  input  logic [NBIT-1:0] tx_data,
  output logic            sr_clk_en,
  output logic            sr_shift_load_n,
  output logic [NBIT-1:0] sr_d,
  input  logic            sr_q0,
  output logic            txd,
  output logic            busy
);

  localparam int BW = cnt_w(NBIT + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(NBIT - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_ctrl: CLKS_PER_BIT must be at least 2");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
    $error("uart_tx_ctrl: STOP_BITS must be 1 or 2");
  end

  tx_state_e     state;
  logic [BW-1:0] bit_cnt;
  logic          par_bit;
  logic          tick;
  logic          baud_restart;
  logic          load;

  // Reset beats a simultaneous request so the register is never loaded under rst.
  assign load         = (state == IDLE) && tx_valid && tx_ready && !rst;
  assign baud_restart = (state == IDLE);

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .restart(baud_restart),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            state    <= START;
            bit_cnt  <= '0;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        START: if (tick) state <= DATA;
        DATA: begin
          if (tick) begin
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              state   <= (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PARITY: if (tick) state <= STOP;
        STOP: begin
          // bit_cnt is reused to count stop-bit periods.
          if (tick) begin
            if (bit_cnt == LAST_STOP) begin
              bit_cnt  <= '0;
              state    <= IDLE;
              tx_ready <= 1'b1;
              busy     <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Parity is frozen at the handshake so later tx_data changes cannot alter it.
  always_ff @(posedge clk) begin
    if (load) par_bit <= (^tx_data) ^ 1'(PARITY_ODD);
  end

  always_comb begin
    sr_clk_en       = 1'b0;
    sr_shift_load_n = 1'b1;
    sr_d            = '0;
    txd             = 1'b1;
    case (state)
      IDLE: begin
        if (load) begin
          sr_clk_en       = 1'b1;
          sr_shift_load_n = 1'b0;
          sr_d            = tx_data;
        end
      end
      START:  txd = 1'b0;
      DATA: begin
        txd       = sr_q0;
        sr_clk_en = tick && !rst;
      end
      PARITY: txd = par_bit;
      STOP:   txd = 1'b1;
      default: txd = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: four configurations share stimulus, each with its own shift register.
module tb_uart_tx_ctrl;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid;
  logic [7:0] tx_data;

  // Index 0: plain, 1: even parity, 2: odd parity, 3: two stop bits.
  logic [3:0] tx_ready, busy, sr_clk_en, sr_sl_n, sr_q0, txd;
  logic [7:0] sr_d [4];
  logic [7:0] sr   [4];

  logic [3:0] txd_log  [0:99];
  logic [3:0] rdy_log  [0:99];
  logic [3:0] busy_log [0:99];
  int         shifts [4];
  int         loads  [4];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl #(.NBIT(8), .CLKS_PER_BIT(C), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_plain (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready[0]), .tx_data(tx_data),
    .sr_clk_en(sr_clk_en[0]), .sr_shift_load_n(sr_sl_n[0]), .sr_d(sr_d[0]), .sr_q0(sr_q0[0]),
    .txd(txd[0]), .busy(busy[0]));

  uart_tx_ctrl #(.NBIT(8), .CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_even (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready[1]), .tx_data(tx_data),
    .sr_clk_en(sr_clk_en[1]), .sr_shift_load_n(sr_sl_n[1]), .sr_d(sr_d[1]), .sr_q0(sr_q0[1]),
    .txd(txd[1]), .busy(busy[1]));

  uart_tx_ctrl #(.NBIT(8), .CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_odd (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready[2]), .tx_data(tx_data),
    .sr_clk_en(sr_clk_en[2]), .sr_shift_load_n(sr_sl_n[2]), .sr_d(sr_d[2]), .sr_q0(sr_q0[2]),
    .txd(txd[2]), .busy(busy[2]));

  uart_tx_ctrl #(.NBIT(8), .CLKS_PER_BIT(C), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_stop2 (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready[3]), .tx_data(tx_data),
    .sr_clk_en(sr_clk_en[3]), .sr_shift_load_n(sr_sl_n[3]), .sr_d(sr_d[3]), .sr_q0(sr_q0[3]),
    .txd(txd[3]), .busy(busy[3]));

  // External right-shift registers: serial-in at MSB (fed 1), LSB is the serial bit.
  always @(posedge clk) begin
    for (int j = 0; j < 4; j++) begin
      if (sr_clk_en[j] === 1'b1) sr[j] <= sr_sl_n[j] ? {1'b1, sr[j][7:1]} : sr_d[j];
    end
  end
  assign sr_q0 = {sr[3][0], sr[2][0], sr[1][0], sr[0][0]};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    step();
    rst = 1'b0;
  endtask

  // Log n cycles starting with the current one, counting shift and load pulses.
  task automatic capture(input int n);
    for (int j = 0; j < 4; j++) begin
      shifts[j] = 0;
      loads[j]  = 0;
    end
    for (int c = 0; c < n; c++) begin
      txd_log[c]  = txd;
      rdy_log[c]  = tx_ready;
      busy_log[c] = busy;
      for (int j = 0; j < 4; j++) begin
        if (sr_clk_en[j] === 1'b1) begin
          if (sr_sl_n[j] === 1'b1) shifts[j]++;
          else                     loads[j]++;
        end
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    step();
    step();
    n_cmp++; if (sr_clk_en !== 4'b0000) begin n_bad++; $display("FAIL rst_vs_valid_clk_en: got %b want 0000", sr_clk_en); end
    n_cmp++; if (tx_ready !== 4'b1111) begin n_bad++; $display("FAIL rst_ready: got %b want 1111", tx_ready); end
    tx_valid = 1'b0;
    rst      = 1'b0;
    #1;
    n_cmp++; if (txd !== 4'b1111) begin n_bad++; $display("FAIL rst_txd: got %b want 1111", txd); end
    n_cmp++; if (busy !== 4'b0000) begin n_bad++; $display("FAIL rst_busy: got %b want 0000", busy); end
    n_cmp++; if (sr_sl_n !== 4'b1111) begin n_bad++; $display("FAIL rst_shift_load_n: got %b want 1111", sr_sl_n); end
    n_cmp++; if (sr_d[0] !== 8'h00) begin n_bad++; $display("FAIL rst_sr_d: got %h want 00", sr_d[0]); end
    step();
    n_cmp++; if (busy !== 4'b0000) begin n_bad++; $display("FAIL rst_no_load: busy got %b want 0000", busy); end
  endtask

  task automatic test_frame_a5();
    logic exp_bits [0:9];
    int   low;
    exp_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    #1;
    n_cmp++; if (sr_clk_en[0] !== 1'b1) begin n_bad++; $display("FAIL a5_load_clk_en: got %b want 1", sr_clk_en[0]); end
    n_cmp++; if (sr_sl_n[0] !== 1'b0) begin n_bad++; $display("FAIL a5_load_n: got %b want 0", sr_sl_n[0]); end
    n_cmp++; if (sr_d[0] !== 8'hA5) begin n_bad++; $display("FAIL a5_sr_d: got %h want a5", sr_d[0]); end
    step();
    tx_valid = 1'b0;
    capture(41);
    for (int c = 0; c < 40; c++) begin
      n_cmp++;
      if (txd_log[c][0] !== exp_bits[c / 4]) begin
        n_bad++; $display("FAIL a5_txd cycle %0d: got %b want %b", c, txd_log[c][0], exp_bits[c / 4]);
      end
    end
    low = 0;
    for (int c = 0; c < 41; c++) if (rdy_log[c][0] === 1'b0) low++;
    n_cmp++; if (low != 40) begin n_bad++; $display("FAIL a5_ready_low_cycles: got %0d want 40", low); end
    n_cmp++; if (rdy_log[40][0] !== 1'b1) begin n_bad++; $display("FAIL a5_ready_rise: got %b want 1", rdy_log[40][0]); end
    n_cmp++; if (busy_log[20][0] !== 1'b1) begin n_bad++; $display("FAIL a5_busy_mid: got %b want 1", busy_log[20][0]); end
    n_cmp++; if (busy_log[40][0] !== 1'b0) begin n_bad++; $display("FAIL a5_busy_end: got %b want 0", busy_log[40][0]); end
    n_cmp++; if (shifts[0] != 8) begin n_bad++; $display("FAIL a5_shift_pulses: got %0d want 8", shifts[0]); end
    n_cmp++; if (loads[0] != 0) begin n_bad++; $display("FAIL a5_extra_loads: got %0d want 0", loads[0]); end
  endtask

  task automatic test_back_to_back();
    logic e;
    do_reset();
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    step();
    tx_data = 8'hFF;
    capture(82);
    tx_valid = 1'b0;
    // 0x00 frame: start+data low to 35, stop 36..39, idle 40, then 0xFF frame starts at 41.
    for (int c = 0; c < 81; c++) begin
      e = (c < 36) ? 1'b0 : (c < 41) ? 1'b1 : (c < 45) ? 1'b0 : 1'b1;
      n_cmp++;
      if (txd_log[c][0] !== e) begin
        n_bad++; $display("FAIL b2b_txd cycle %0d: got %b want %b", c, txd_log[c][0], e);
      end
    end
    n_cmp++; if (rdy_log[39][0] !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_39: got %b want 0", rdy_log[39][0]); end
    n_cmp++; if (rdy_log[40][0] !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_40: got %b want 1", rdy_log[40][0]); end
    n_cmp++; if (rdy_log[41][0] !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_41: got %b want 0", rdy_log[41][0]); end
    n_cmp++; if (rdy_log[81][0] !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_81: got %b want 1", rdy_log[81][0]); end
    n_cmp++; if (loads[0] != 2) begin n_bad++; $display("FAIL b2b_loads: got %0d want 2", loads[0]); end
    n_cmp++; if (shifts[0] != 16) begin n_bad++; $display("FAIL b2b_shifts: got %0d want 16", shifts[0]); end
  endtask

  task automatic test_parity();
    logic exp_even [0:10];
    logic exp_odd  [0:10];
    exp_even = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_odd  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    tx_valid = 1'b1;
    tx_data  = 8'h07;
    step();
    tx_valid = 1'b0;
    capture(45);
    for (int c = 0; c < 44; c++) begin
      n_cmp++;
      if (txd_log[c][1] !== exp_even[c / 4]) begin
        n_bad++; $display("FAIL par_even_txd cycle %0d: got %b want %b", c, txd_log[c][1], exp_even[c / 4]);
      end
      n_cmp++;
      if (txd_log[c][2] !== exp_odd[c / 4]) begin
        n_bad++; $display("FAIL par_odd_txd cycle %0d: got %b want %b", c, txd_log[c][2], exp_odd[c / 4]);
      end
    end
    n_cmp++; if (rdy_log[43][1] !== 1'b0) begin n_bad++; $display("FAIL par_even_ready_43: got %b want 0", rdy_log[43][1]); end
    n_cmp++; if (rdy_log[44][1] !== 1'b1) begin n_bad++; $display("FAIL par_even_ready_44: got %b want 1", rdy_log[44][1]); end
    n_cmp++; if (rdy_log[44][2] !== 1'b1) begin n_bad++; $display("FAIL par_odd_ready_44: got %b want 1", rdy_log[44][2]); end
  endtask

  task automatic test_reset_mid();
    logic exp_bits [0:9];
    exp_bits = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    tx_valid = 1'b1;
    tx_data  = 8'hF0;
    step();
    tx_valid = 1'b0;
    repeat (17) step();
    n_cmp++; if (txd[0] !== 1'b0) begin n_bad++; $display("FAIL mid_bit3_txd: got %b want 0", txd[0]); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (txd !== 4'b1111) begin n_bad++; $display("FAIL mid_rst_txd: got %b want 1111", txd); end
    n_cmp++; if (tx_ready !== 4'b1111) begin n_bad++; $display("FAIL mid_rst_ready: got %b want 1111", tx_ready); end
    n_cmp++; if (sr_clk_en !== 4'b0000) begin n_bad++; $display("FAIL mid_rst_clk_en: got %b want 0000", sr_clk_en); end
    n_cmp++; if (busy !== 4'b0000) begin n_bad++; $display("FAIL mid_rst_busy: got %b want 0000", busy); end
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    #1;
    n_cmp++; if (sr_d[0] !== 8'h3C) begin n_bad++; $display("FAIL mid_reload_sr_d: got %h want 3c", sr_d[0]); end
    step();
    tx_valid = 1'b0;
    capture(41);
    for (int c = 0; c < 40; c++) begin
      n_cmp++;
      if (txd_log[c][0] !== exp_bits[c / 4]) begin
        n_bad++; $display("FAIL mid_3c_txd cycle %0d: got %b want %b", c, txd_log[c][0], exp_bits[c / 4]);
      end
    end
    n_cmp++; if (rdy_log[40][0] !== 1'b1) begin n_bad++; $display("FAIL mid_3c_ready: got %b want 1", rdy_log[40][0]); end
    n_cmp++; if (shifts[0] != 8) begin n_bad++; $display("FAIL mid_3c_shifts: got %0d want 8", shifts[0]); end
  endtask

  task automatic test_valid_while_busy();
    logic exp_bits [0:9];
    int   extra;
    exp_bits = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    tx_valid = 1'b1;
    tx_data  = 8'h96;
    step();
    extra = 0;
    for (int c = 0; c < 41; c++) begin
      if (c < 40) begin
        tx_valid = 1'b1;
        tx_data  = (c % 2 == 1) ? 8'h0F : 8'hF0;
      end else begin
        tx_valid = 1'b0;
      end
      #1;
      if (sr_sl_n[0] !== 1'b1) extra++;
      if (c < 40) begin
        n_cmp++;
        if (txd[0] !== exp_bits[c / 4]) begin
          n_bad++; $display("FAIL busy_txd cycle %0d: got %b want %b", c, txd[0], exp_bits[c / 4]);
        end
        n_cmp++;
        if (tx_ready[0] !== 1'b0) begin
          n_bad++; $display("FAIL busy_ready cycle %0d: got %b want 0", c, tx_ready[0]);
        end
      end else begin
        n_cmp++;
        if (tx_ready[0] !== 1'b1) begin
          n_bad++; $display("FAIL busy_ready_end: got %b want 1", tx_ready[0]);
        end
      end
      step();
    end
    n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL busy_extra_load: got %0d want 0", extra); end
  endtask

  task automatic test_stop2();
    logic exp_bits [0:10];
    exp_bits = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    tx_valid = 1'b1;
    tx_data  = 8'h7F;
    step();
    tx_valid = 1'b0;
    capture(45);
    for (int c = 0; c < 44; c++) begin
      n_cmp++;
      if (txd_log[c][3] !== exp_bits[c / 4]) begin
        n_bad++; $display("FAIL stop2_txd cycle %0d: got %b want %b", c, txd_log[c][3], exp_bits[c / 4]);
      end
    end
    n_cmp++; if (rdy_log[43][3] !== 1'b0) begin n_bad++; $display("FAIL stop2_ready_43: got %b want 0", rdy_log[43][3]); end
    n_cmp++; if (rdy_log[44][3] !== 1'b1) begin n_bad++; $display("FAIL stop2_ready_44: got %b want 1", rdy_log[44][3]); end
    n_cmp++; if (shifts[3] != 8) begin n_bad++; $display("FAIL stop2_shifts: got %0d want 8", shifts[3]); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    test_reset();
    test_frame_a5();
    test_back_to_back();
    test_parity();
    test_reset_mid();
    test_valid_while_busy();
    test_stop2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
